// File: rtl/gost_pipe_axis.sv
// gost_pipe_axis: elastic pipelined Feistel block cipher with AXI-Stream ports and per-beat encrypt/decrypt.
// Define GOST_PIPE_WHITEN_EN to add pre/post key whitening around the rounds.
module gost_pipe_axis #(
   parameter int BLOCK_W = 64,
   parameter int ROUNDS  = 32,
   parameter int STAGES  = 8,
   parameter int ROT     = 11
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [8*(BLOCK_W/2)-1:0]  key,
   input  logic [BLOCK_W-1:0]        s_axis_tdata,
   input  logic                      s_axis_tuser,
   input  logic                      s_axis_tlast,
   input  logic                      s_axis_tvalid,
   output logic                      s_axis_tready,
   output logic [BLOCK_W-1:0]        m_axis_tdata,
   output logic                      m_axis_tuser,
   output logic                      m_axis_tlast,
   output logic                      m_axis_tvalid,
   input  logic                      m_axis_tready,
   output logic                      idle
);
   localparam int HALF = BLOCK_W / 2;
   localparam int RPS  = ROUNDS / STAGES;

   function automatic logic [HALF-1:0] f(input logic [HALF-1:0] x, input logic [HALF-1:0] k);
      logic [HALF-1:0] s;
      s = x + k;
      return (s << ROT) | (s >> (HALF - ROT));
   endfunction

   // Applies this stage's slice of rounds; decrypt walks the key schedule backwards.
   function automatic logic [BLOCK_W-1:0] rounds(input logic [BLOCK_W-1:0] d, input logic m,
                                                 input int base, input logic [8*HALF-1:0] k);
      logic [HALF-1:0] l, r, t;
      int n;
      {l, r} = d;
      for (int i = 0; i < RPS; i++) begin
         n = m ? (ROUNDS - 1 - base - i) % 8 : (base + i) % 8;
         t = l ^ f(r, k[n*HALF +: HALF]);
         l = r;
         r = t;
      end
      return {l, r};
   endfunction

   logic [BLOCK_W-1:0] pre, post;
`ifdef GOST_PIPE_WHITEN_EN
   always_comb begin
      pre  = s_axis_tuser ? key[2*BLOCK_W-1:BLOCK_W] : key[BLOCK_W-1:0];
      post = m_axis_tuser ? key[BLOCK_W-1:0] : key[2*BLOCK_W-1:BLOCK_W];
   end
`else
   assign pre  = '0;
   assign post = '0;
`endif

   logic [STAGES-1:0] vld;

   for (genvar g = 0; g < STAGES; g++) begin : st
      logic [BLOCK_W-1:0] d, src;
      logic v, m, l, rdy, src_v, src_m, src_l;
      if (g == 0) begin : head
         assign src   = s_axis_tdata ^ pre;
         assign src_v = s_axis_tvalid;
         assign src_m = s_axis_tuser;
         assign src_l = s_axis_tlast;
      end else begin : body
         assign src   = st[g-1].d;
         assign src_v = st[g-1].v;
         assign src_m = st[g-1].m;
         assign src_l = st[g-1].l;
      end
      // An empty stage is always ready, so stalls only propagate through full stages.
      if (g == STAGES - 1) begin : tail
         assign rdy = !v || m_axis_tready;
      end else begin : mid
         assign rdy = !v || st[g+1].rdy;
      end
      always_ff @(posedge clk)
         if (rst) begin
            v <= 1'b0;
            d <= '0;
            m <= 1'b0;
            l <= 1'b0;
         end else if (rdy) begin
            v <= src_v;
            d <= rounds(src, src_m, g * RPS, key);
            m <= src_m;
            l <= src_l;
         end
      assign vld[g] = v;
   end

   assign s_axis_tready = st[0].rdy;
   assign m_axis_tvalid = st[STAGES-1].v;
   assign m_axis_tuser  = st[STAGES-1].m;
   assign m_axis_tlast  = st[STAGES-1].l;
   assign m_axis_tdata  = {st[STAGES-1].d[HALF-1:0], st[STAGES-1].d[BLOCK_W-1:HALF]} ^ post;
   assign idle          = ~|vld;
endmodule

// File: doc/gost_pipe_axis.md
# gost_pipe_axis

Parametrised, fully pipelined Feistel block-cipher engine with AXI-Stream input and output and a per-beat encrypt/decrypt mode. It is the next generation of the team's 8-stage GOST-style pipeline. Round count, block width and pipeline depth are configurable. Each stage has its own elastic valid/ready, so a downstream stall collapses bubbles instead of freezing the whole pipe. It sits between the DMA ingress stream and the packet framer, and carries tlast and mode alongside the data.

## Interface
- BLOCK_W, 64: block width in bits; must be even; HALF = BLOCK_W/2.
- ROUNDS, 32: Feistel rounds; must be a multiple of STAGES.
- STAGES, 8: pipeline register stages; RPS = ROUNDS/STAGES rounds are evaluated combinationally per stage.
- ROT, 11: left-rotate amount in the round function; must satisfy 0 < ROT < HALF.
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- key  in  8*HALF  key material, with words K[j] = key[j*HALF +: HALF]; quasi-static.
- s_axis_tdata  in  BLOCK_W  input block, where L = upper half and R = lower half.
- s_axis_tuser  in  1  mode: 0 = encrypt, 1 = decrypt.
- s_axis_tlast  in  1  passed through unchanged.
- s_axis_tvalid  in  1 / s_axis_tready  out  1: input handshake.
- m_axis_tdata  out  BLOCK_W, m_axis_tuser  out  1, m_axis_tlast  out  1: result, echoed mode and echoed tlast.
- m_axis_tvalid  out  1 / m_axis_tready  in  1: output handshake.
- idle  out  1: high when no stage holds a valid beat.

## Operation
- Round function: F(x,k) = rotl((x + k) mod 2^HALF, ROT).
- Round step: (L,R) -> (R, L ^ F(R,k_r)).
- Round key selection:
  - Encrypt: k_r = K[r mod 8].
  - Decrypt: k_r = K[(ROUNDS-1-r) mod 8].
- Output swap: after the last round the output is {R_n, L_n}. Decrypt therefore exactly inverts encrypt for the same key.
- Stage s register holds the beat after rounds s*RPS .. s*RPS+RPS-1.
  - Stage 0 applies its rounds to the accepted input (after optional whitening).
  - Each stage carries data, mode and tlast, plus a valid bit.
- Elastic flow control:
  - ready_S = m_axis_tready.
  - ready_s = !valid_s || ready_{s+1}.
  - s_axis_tready = ready_0. This is a combinational chain; no stage register ever drops or duplicates a beat.
  - Stage s loads from stage s-1 when ready_s is high. Its valid becomes valid_{s-1}; for stage 0, valid becomes s_axis_tvalid.
- Output path: m_axis_* is driven combinationally from the last stage register plus the output swap and optional post-whitening. m_axis_tvalid = valid_{S-1}.
- Key changes:
  - key must only change while idle = 1 and no input handshake is occurring.
  - A key change while beats are in flight produces undefined output data but must not corrupt the handshakes.
- Mode may differ beat to beat; each beat uses its own mode in every stage.

## Timing
- Reset: all stage valid bits = 0, so m_axis_tvalid = 0, s_axis_tready = 1 and idle = 1. Data, tuser and tlast registers reset to 0.
- Reset mid-stream: all in-flight beats are discarded. The first accept after rst deasserts happens in the first cycle with rst = 0.
- Latency: a beat accepted in cycle t has m_axis_tvalid = 1 in cycle t+STAGES, provided no stall occurs.
- Throughput: 1 beat per cycle while m_axis_tready = 1.
- Stall behaviour:
  - m_axis_tready = 0 holds the last stage.
  - Upstream stages keep advancing until each has filled.
  - s_axis_tready falls only when all STAGES registers are valid.
  - A full pipe accepts a new beat in the same cycle that a beat leaves.
- m_axis_tdata, m_axis_tuser and m_axis_tlast stay stable while m_axis_tvalid = 1 and m_axis_tready = 0.

## Configuration
- GOST_PIPE_WHITEN_EN defined: key whitening is added, with W0 = key[BLOCK_W-1:0] and W1 = key[2*BLOCK_W-1:BLOCK_W].
  - Encrypt: XOR the input with W0 before round 0, and XOR the output with W1 after the swap.
  - Decrypt: use W1 before and W0 after, so decrypt still inverts encrypt.
  - No latency change.
- GOST_PIPE_WHITEN_EN undefined: no whitening, and the datapath is the bare Feistel.

## Test plan
- Zero case: key = 0, block 0x0000000000000000 with encrypt, and separately with decrypt, with whitening off -> output 0x0000000000000000, arriving exactly STAGES = 8 cycles after accept.
- Round trip: key = 0x0123456789ABCDEF_FEDCBA9876543210_0F1E2D3C4B5A6978_8796A5B4C3D2E1F0, block 0x0011223344556677.
  - Encrypt, then feed the result back with tuser = 1 -> output 0x0011223344556677.
  - Repeat with GOST_PIPE_WHITEN_EN defined.
- Backpressure: 64 random beats with random tvalid and a random m_axis_tready duty of 30% -> all 64 results match the model, in order, with tlast and tuser aligned and no drops or duplicates.
- Fill/stall:
  - Hold m_axis_tready = 0 and offer 10 beats -> exactly 8 are accepted and s_axis_tready = 0.
  - Release -> 10 beats out back-to-back, with one new beat accepted per beat drained.
- Mixed mode: alternate encrypt/decrypt every beat at full rate -> each output matches its own mode's model, and throughput is 1 beat per cycle.
- Reset mid-stream: assert rst for 1 cycle with 5 beats in flight -> m_axis_tvalid = 0 and idle = 1 in the next cycle, and none of the 5 beats is ever emitted.
